// File: rtl/d_sram_to_sram_like_p.sv
// -----------------------------------------------------------------------------
// d_sram_to_sram_like_p
// Data-side bridge from the CPU's SRAM-style port to a single sram-like
// transaction per access. The pipeline stays stalled until the transaction
// completes. The completed result is then held while the global stall
// (longest_stall) is high.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   d_stall           : stall request to the pipeline
//   longest_stall     : global stall; while high the bridge parks in DONE
//   data_sram_*       : CPU side (en, byte wen, byte addr, lane-aligned wdata,
//                       captured rdata)
//   data_*            : sram-like side (req, wr, size, addr, wdata, rdata,
//                       addr_ok, data_ok)
//   perf_access_cnt   : saturating count of completed transactions
//   perf_stall_cnt    : saturating count of cycles with d_stall high
// -----------------------------------------------------------------------------
module d_sram_to_sram_like_p #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              d_stall,
  input  logic              longest_stall,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic [31:0]       data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic [CNT_W-1:0]  perf_access_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               is_read_q, is_read_d;
  logic [31:0]        rdata_save_q, rdata_save_d;
  logic [CNT_W-1:0]   access_cnt_q, access_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               enter_done_s;
  logic [3:0]         decode_s;
  logic               addr_lo_unused_s;

  // Byte-enable pattern to {size, addr[1:0]}; anything irregular is a word.
  function automatic logic [3:0] decode_wen(input logic [3:0] wen);
    logic [3:0] res;
    case (wen)
      4'b0001: res = {2'd0, 2'd0};
      4'b0010: res = {2'd0, 2'd1};
      4'b0100: res = {2'd0, 2'd2};
      4'b1000: res = {2'd0, 2'd3};
      4'b0011: res = {2'd1, 2'd0};
      4'b1100: res = {2'd1, 2'd2};
      default: res = {2'd2, 2'd0};
    endcase
    return res;
  endfunction

  // The offset comes from the byte enables, so the CPU's low address bits are unused.
  assign addr_lo_unused_s = ^data_sram_addr[1:0];

  assign decode_s        = decode_wen(data_sram_wen);
  assign data_wr         = |data_sram_wen;
  assign data_size       = decode_s[3:2];
  assign data_addr       = {data_sram_addr[ADDR_W-1:2], decode_s[1:0]};
  assign data_wdata      = data_sram_wdata;
  assign data_sram_rdata = rdata_save_q;
  assign d_stall         = data_sram_en & (state_q != ST_DONE);
  assign perf_access_cnt = access_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;

  // Next-state, request strobe and read capture.
  always_comb begin
    state_d      = state_q;
    is_read_d    = is_read_q;
    rdata_save_d = rdata_save_q;
    data_req     = 1'b0;
    enter_done_s = 1'b0;
    case (state_q)
      ST_ADDR: begin
        data_req = data_sram_en;
        if (data_sram_en & data_addr_ok) begin
          // Remember the type so WAIT knows whether to capture data.
          is_read_d = ~data_wr;
          if (data_data_ok) begin
            state_d      = ST_DONE;
            enter_done_s = 1'b1;
            if (~data_wr) begin
              rdata_save_d = data_rdata;
            end else begin
              rdata_save_d = rdata_save_q;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d      = ST_DONE;
          enter_done_s = 1'b1;
          if (is_read_q) begin
            rdata_save_d = data_rdata;
          end else begin
            rdata_save_d = rdata_save_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Result is held here until the whole pipeline may advance.
        if (~longest_stall) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ADDR;
      end
    endcase
  end

  // Saturating performance counter next values.
  always_comb begin
    access_cnt_d = access_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (enter_done_s && (access_cnt_q != {CNT_W{1'b1}})) begin
      access_cnt_d = access_cnt_q + CNT_W'(1'b1);
    end else begin
      access_cnt_d = access_cnt_q;
    end
    if (d_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, captured data and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ADDR;
      is_read_q    <= 1'b0;
      rdata_save_q <= 32'h0000_0000;
      access_cnt_q <= {CNT_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      is_read_q    <= is_read_d;
      rdata_save_q <= rdata_save_d;
      access_cnt_q <= access_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: doc/d_sram_to_sram_like_p.md
Name: d_sram_to_sram_like_p

Overview:
- Parametrised data-side bridge that converts the CPU's SRAM-style data port (enable, byte write-enable, address, wdata) into one sram-like transaction per access.
- Next generation of the instruction-side converter. Adds writes, byte-enable to size/address-offset decoding, a configurable address width, read-only data capture, and saturating stall/access performance counters.
- Sits between the MEM stage and the sram-like-to-AXI bridge.
- Stalls the pipeline until the transaction completes. Holds the result until the global stall (longest_stall) releases.

Parameters:
- ADDR_W, 32, width of data_sram_addr and data_addr.
- CNT_W, 32, width of each performance counter (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- d_stall  out  1  pipeline stall request from this bridge
- longest_stall  in  1  global pipeline stall; the bridge holds its result while this is high
- data_sram_en  in  1  access request from the CPU
- data_sram_wen  in  4  byte write enables; 0 means a read
- data_sram_addr  in  ADDR_W  byte address
- data_sram_wdata  in  32  write data, already lane-aligned
- data_sram_rdata  out  32  captured read data
- data_req  out  1  sram-like request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  ADDR_W  sram-like address
- data_wdata  out  32  passthrough of data_sram_wdata
- data_rdata  in  32  sram-like read data
- data_addr_ok  in  1  address handshake
- data_data_ok  in  1  data handshake
- perf_access_cnt  out  CNT_W  completed transactions
- perf_stall_cnt  out  CNT_W  cycles with d_stall=1

Behaviour:
- Synchronous active-high reset, single clock domain. Reset state:
  - FSM in ADDR
  - rdata_save = 0
  - both counters = 0
  - all outputs derive from this state, so data_req = data_sram_en and d_stall = data_sram_en.
- Reset mid-transaction:
  - Returns the FSM to ADDR.
  - Any data_data_ok arriving afterwards without a new acceptance is ignored.
- FSM states: ADDR, WAIT, DONE.
- ADDR:
  - data_req = data_sram_en (combinational, same cycle).
  - Next state when data_req & data_addr_ok & data_data_ok: DONE.
  - Next state when data_req & data_addr_ok & ~data_data_ok: WAIT.
  - Otherwise stay in ADDR.
  - data_data_ok without acceptance in the same cycle is ignored.
- WAIT:
  - data_req = 0.
  - On data_data_ok, go to DONE.
- DONE:
  - data_req = 0.
  - If ~longest_stall, go to ADDR.
  - Otherwise stay; data_data_ok in DONE is ignored.
- d_stall = data_sram_en & (state != DONE).
- Read capture:
  - rdata_save <= data_rdata on the completing data_data_ok, only if the accepted transaction was a read.
  - Writes leave rdata_save unchanged.
  - A read/write flag is registered at acceptance so WAIT knows the type.
  - data_sram_rdata = rdata_save.
- Request decode (combinational from CPU inputs; valid while data_req is high):
  - data_wr = |data_sram_wen.
  - Read: size 2, addr[1:0] = 00.
  - wen 0001 / 0010 / 0100 / 1000: size 0, addr[1:0] = 00 / 01 / 10 / 11.
  - wen 0011 / 1100: size 1, addr[1:0] = 00 / 10.
  - wen 1111: size 2, addr[1:0] = 00.
  - Any other nonzero wen: size 2, addr[1:0] = 00 (word write).
  - Upper bits: data_addr[ADDR_W-1:2] = data_sram_addr[ADDR_W-1:2].
- data_wdata = data_sram_wdata (the CPU holds it through the stall).
- Latency:
  - Minimum is 1 cycle of d_stall, when addr_ok and data_ok arrive in the same cycle.
  - Otherwise 1 + (cycles to addr_ok) + (cycles in WAIT).
- Counters (both saturate at all-ones, no wrap):
  - perf_access_cnt increments by 1 on each transition into DONE.
  - perf_stall_cnt increments every cycle d_stall = 1.

Test Plan:
- Word read, addr_ok and data_ok in the same cycle, data_rdata = 0xDEADBEEF, longest_stall = 0:
  - data_req=1, size=2, wr=0 for 1 cycle
  - d_stall=1 for 1 cycle
  - next cycle rdata=0xDEADBEEF, d_stall=0
  - perf_access_cnt=1
- Byte write, wen=0100, addr=0x1000_0003:
  - data_addr=0x1000_0002, size=0, wr=1
  - addr_ok at cycle 2, data_ok at cycle 4
  - d_stall high 4 cycles
  - rdata unchanged from the prior read
  - perf_stall_cnt=4
- Half write, wen=1100: size=1, addr[1:0]=10. Illegal wen=0110: size=2, addr[1:0]=00, wr=1.
- longest_stall held high 3 cycles after data_ok:
  - FSM stays in DONE, data_req=0, no second request issued
  - spurious data_ok in DONE does not change rdata
  - on release, a new request appears the next cycle.
- Reset asserted in WAIT:
  - FSM returns to ADDR, counters=0, rdata=0
  - a late data_ok is ignored
  - data_req = data_sram_en after reset.
- Counter saturation with CNT_W=2:
  - 5 accesses give perf_access_cnt=3
  - perf_stall_cnt stays at 3.
